// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: iterative AES-128 inverse key schedule, rounds 10..0.
// Optional macro INV_KS_FULL_BUS_EN adds the round_keys bus and keys_valid.
module aes_inv_key_schedule (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [127:0]  last_key,
   output logic [127:0]  round_key,
   output logic [3:0]    round_idx,
   output logic          rk_valid,
   input  logic          rk_ready,
   output logic          busy,
   output logic          done
`ifdef INV_KS_FULL_BUS_EN
   ,
   output logic [1407:0] round_keys,
   output logic          keys_valid
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]],
              SBOX[w[15:8]],  SBOX[w[7:0]]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      c = 8'h00;
      unique case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   state_t state, state_n;
   logic   load, step, fin, beat;

   logic [31:0]  k0, k1, k2, k3;
   logic [31:0]  p0, p1, p2, p3;
   logic [127:0] prev_key;

   // Undo one forward KeyExpansion round from the registered key.
   always_comb begin
      k0 = round_key[127:96];
      k1 = round_key[95:64];
      k2 = round_key[63:32];
      k3 = round_key[31:0];
      p3 = k3 ^ k2;
      p2 = k2 ^ k1;
      p1 = k1 ^ k0;
      p0 = k0 ^ sub_word({p3[23:0], p3[31:24]})
         ^ {rcon(round_idx), 24'h0};
      prev_key = {p0, p1, p2, p3};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state and datapath control.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            if (rk_ready) begin
               if (round_idx == 4'd0) begin
                  fin     = 1'b1;
                  state_n = S_DONE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign beat     = (state == S_RUN) && rk_ready;
   assign rk_valid = (state == S_RUN);
   assign busy     = (state == S_RUN);
   assign done     = (state == S_DONE);

   // Round key and index: load on start, step back on each beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         round_key <= '0;
         round_idx <= '0;
      end else if (load) begin
         round_key <= last_key;
         round_idx <= 4'd10;
      end else if (step) begin
         round_key <= prev_key;
         round_idx <= round_idx - 4'd1;
      end
   end

`ifdef INV_KS_FULL_BUS_EN
   // Capture each delivered key into its forward-order slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         round_keys <= '0;
         keys_valid <= 1'b0;
      end else begin
         if (load) keys_valid <= 1'b0;
         if (fin)  keys_valid <= 1'b1;
         for (int r = 0; r < 11; r++) begin
            if (beat && round_idx == 4'(r))
               round_keys[(10-r)*128 +: 128] <= round_key;
         end
      end
   end
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: randomized checks against a forward
// KeyExpansion model with an arithmetic S-box.
module tb_aes_inv_key_schedule;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [127:0]  last_key;
   logic [127:0]  round_key;
   logic [3:0]    round_idx;
   logic          rk_valid;
   logic          rk_ready;
   logic          busy;
   logic          done;
`ifdef INV_KS_FULL_BUS_EN
   logic [1407:0] round_keys;
   logic          keys_valid;
   logic [1407:0] snap_bus;
   logic          snap_kv;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [127:0] exp_rk[0:10];
   logic [127:0] got_key[0:10];
   logic [3:0]   got_idx[0:10];
   int nb, done_n, last_beat_n, stalls, extra;

   always #5 clk = ~clk;

   aes_inv_key_schedule dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .last_key  (last_key),
      .round_key (round_key),
      .round_idx (round_idx),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .busy      (busy),
      .done      (done)
`ifdef INV_KS_FULL_BUS_EN
      ,
      .round_keys(round_keys),
      .keys_valid(keys_valid)
`endif
   );

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
      return (x << k) | (x >> (8 - k));
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv;
      inv = x;
      if (x == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 253; i++) inv = gmul(inv, x);
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2)
           ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   // Forward KeyExpansion from the round-0 key.
   task automatic expand(input logic [127:0] k0);
      logic [31:0] w[0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]),
                 sbox_ref(t[15:8]),  sbox_ref(t[7:0])};
            t = t ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic do_start(input logic [127:0] key);
      start    = 1'b1;
      last_key = key;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Drives rk_ready and records beats until done or timeout.
   task automatic collect(input int pct, input int inj_idx,
                          input logic [127:0] inj_key);
      logic         stall;
      logic [127:0] pk;
      logic [3:0]   pi;
      logic         rdy;
      nb = 0; done_n = -1; last_beat_n = -1;
      stalls = 0; extra = 0; stall = 1'b0;
      pk = '0; pi = '0;
      for (int n = 1; n <= 200; n++) begin
         if (stall && (round_key !== pk || round_idx !== pi))
            stalls++;
         if (done === 1'b1) begin
            done_n = n;
`ifdef INV_KS_FULL_BUS_EN
            snap_bus = round_keys;
            snap_kv  = keys_valid;
`endif
            break;
         end
         rdy = ($urandom_range(99) < pct);
         rk_ready = rdy;
         start = (inj_idx >= 0 && rk_valid === 1'b1 &&
                  round_idx == 4'(inj_idx));
         if (start) last_key = inj_key;
         if (rk_valid === 1'b1 && rdy) begin
            if (nb < 11) begin
               got_key[nb] = round_key;
               got_idx[nb] = round_idx;
               nb++;
            end else extra++;
            last_beat_n = n;
         end
         stall = (rk_valid === 1'b1) && !rdy;
         pk = round_key;
         pi = round_idx;
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_sequence(input string name, input logic [127:0] k0,
                                input int pct, input int inj_idx,
                                input logic [127:0] inj_key);
      expand(k0);
      do_start(exp_rk[10]);
      collect(pct, inj_idx, inj_key);
      vectors++;
      if (done_n < 0) begin
         miscompares++;
         $display("FAIL %s_timeout done never seen, required within 200",
                  name);
      end
      vectors++;
      if (nb != 11 || extra != 0) begin
         miscompares++;
         $display("FAIL %s_beats got %0d (+%0d extra) required 11",
                  name, nb, extra);
      end
      for (int i = 0; i < nb; i++) begin
         vectors++;
         if (got_key[i] !== exp_rk[10-i] || got_idx[i] !== 4'(10-i)) begin
            miscompares++;
            $display("FAIL %s_beat%0d got %h/%0d required %h/%0d", name,
                     i, got_key[i], got_idx[i], exp_rk[10-i], 10-i);
         end
      end
      vectors++;
      if (stalls != 0) begin
         miscompares++;
         $display("FAIL %s_stall got %0d unstable cycles required 0",
                  name, stalls);
      end
      vectors++;
      if (done_n - last_beat_n != 1) begin
         miscompares++;
         $display("FAIL %s_done_lat got %0d required 1",
                  name, done_n - last_beat_n);
      end
      if (pct >= 100) begin
         vectors++;
         if (done_n != 12) begin
            miscompares++;
            $display("FAIL %s_start_to_done got %0d required 12",
                     name, done_n);
         end
      end
`ifdef INV_KS_FULL_BUS_EN
      begin
         logic [1407:0] eb;
         for (int r = 0; r < 11; r++) eb[(10-r)*128 +: 128] = exp_rk[r];
         vectors++;
         if (snap_bus !== eb || snap_kv !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_bus kv=%b required kv=1, bus ok=%0d",
                     name, snap_kv, snap_bus === eb);
         end
      end
`endif
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_after_done done=%b busy=%b valid=%b required 0",
                  name, done, busy, rk_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; rk_ready = 1'b1;
      last_key = {$urandom, $urandom, $urandom, $urandom};
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (round_key !== '0 || round_idx !== 4'd0 || rk_valid !== 1'b0 ||
             busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle%0d key=%h idx=%0d v=%b b=%b d=%b required 0",
                     i, round_key, round_idx, rk_valid, busy, done);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_standard();
      logic [127:0] c[0:3];
      int           bi[0:3];
      c[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; bi[0] = 0;
      c[1] = 128'hac7766f319fadc2128d12941575c006e; bi[1] = 1;
      c[2] = 128'ha0fafe1788542cb123a339392a6c7605; bi[2] = 9;
      c[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c; bi[3] = 10;
      test_sequence("std", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    100, -1, '0);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (got_key[bi[i]] !== c[i]) begin
            miscompares++;
            $display("FAIL std_known idx%0d got %h required %h",
                     10 - bi[i], got_key[bi[i]], c[i]);
         end
      end
   endtask

   task automatic test_zero_key();
      test_sequence("zero", '0, 100, -1, '0);
      vectors++;
      if (got_key[1] !== 128'hb1d4d8e28a7db9da1d7bb3de4c664941 ||
          got_key[9] !== 128'h62636363626363636263636362636363 ||
          got_key[10] !== '0) begin
         miscompares++;
         $display("FAIL zero_known got %h %h %h", got_key[1],
                  got_key[9], got_key[10]);
      end
   endtask

   task automatic test_backpressure();
      test_sequence("bp", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    50, -1, '0);
   endtask

   task automatic test_abuse();
      int dn;
      test_sequence("late_start", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    100, 5, 128'h0123456789abcdeffedcba9876543210);
      do_start(exp_rk[10]);
      rk_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (rk_valid === 1'b1 && round_idx == 4'd6) break;
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      vectors++;
      if (round_key !== '0 || round_idx !== 4'd0 || rk_valid !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_reset key=%h idx=%0d v=%b b=%b d=%b required 0",
                  round_key, round_idx, rk_valid, busy, done);
      end
`ifdef INV_KS_FULL_BUS_EN
      vectors++;
      if (keys_valid !== 1'b0 || round_keys !== '0) begin
         miscompares++;
         $display("FAIL midrun_reset_bus kv=%b required 0", keys_valid);
      end
`endif
      dn = 0;
      for (int n = 0; n < 15; n++) begin
         if (done === 1'b1 || busy === 1'b1) dn++;
         @(posedge clk); #1;
      end
      vectors++;
      if (dn != 0) begin
         miscompares++;
         $display("FAIL reset_no_done got %0d active cycles required 0", dn);
      end
      test_sequence("restart", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    100, -1, '0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 3; t++)
         test_sequence("rand",
                       {$urandom, $urandom, $urandom, $urandom},
                       70, -1, '0);
   endtask

`ifdef INV_KS_FULL_BUS_EN
   task automatic test_full_bus();
      test_sequence("bus", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    100, -1, '0);
      vectors++;
      if (keys_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL bus_kv_hold got %b required 1", keys_valid);
      end
      do_start(exp_rk[10]);
      vectors++;
      if (keys_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bus_kv_clear got %b required 0", keys_valid);
      end
      collect(100, -1, '0);
   endtask
`endif

   initial begin
      rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; last_key = '0;
      test_reset();
      test_standard();
      test_zero_key();
      test_backpressure();
      test_abuse();
      test_random();
`ifdef INV_KS_FULL_BUS_EN
      test_full_bus();
`endif
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
